wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameters: none; widths are fixed at 32-bit data and 5-bit register address.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port mem_wd, input, 5, destination register address from the MEM stage.
REQ-005 SHALL have port mem_wreg, input, 1, write-enable from the MEM stage (1 = write).
REQ-006 SHALL have port mem_wdata, input, 32, write data from the MEM stage.
REQ-007 SHALL have port stall, input, 1, hold the MEM/WB stage register.
REQ-008 SHALL have port flush, input, 1, load a bubble into the MEM/WB stage register.
REQ-009 SHALL have ports re1/re2, input, 1 each, read enables for ports 1 and 2.
REQ-010 SHALL have ports raddr1/raddr2, input, 5 each, read addresses.
REQ-011 SHALL have ports rdata1/rdata2, output, 32 each, read data (combinational).
REQ-012 SHALL have ports wb_wd/wb_wreg/wb_wdata, output, 5/1/32, registered WB-stage contents, exported for forwarding.

Function
REQ-013 SHALL hold a 32 x 32-bit register array; entry 0 SHALL always read 0 and SHALL never be written.
REQ-014 SHALL update the WB stage register at each rising edge in priority order: rst, then flush, then stall, then capture.
REQ-015 On flush, SHALL load wb_wreg=0, wb_wd=0, wb_wdata=0x00000000, regardless of stall.
REQ-016 On stall (without flush), SHALL hold wb_wd/wb_wreg/wb_wdata unchanged.
REQ-017 Otherwise, SHALL capture mem_wd/mem_wreg/mem_wdata into wb_wd/wb_wreg/wb_wdata.
REQ-018 At each rising edge with rst=0, wb_wreg=1 and wb_wd!=0, SHALL write wb_wdata to array[wb_wd]; this write SHALL still occur while stall=1 (a repeated identical write is harmless).
REQ-019 SHALL make MEM-stage data visible in the WB outputs one edge after presentation, and in array reads two edges after presentation.
REQ-020 Each read port n SHALL output 0 when rst=1, else 0 when raddrn=0, else 0 when ren=0.
REQ-021 Otherwise, if wb_wreg=1 and raddrn=wb_wd, read port n SHALL output wb_wdata (write-through bypass).
REQ-022 Otherwise, read port n SHALL output array[raddrn].
REQ-023 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-024 A mem_wreg=0 entry SHALL never modify the array, whatever mem_wd and mem_wdata are.

Reset
REQ-025 With rst=1 at an edge, SHALL clear wb_wd=0, wb_wreg=0, wb_wdata=0, and all 32 array entries to 0.
REQ-026 Reset mid-operation SHALL discard any pending WB-stage write, so no array write occurs on that edge.
REQ-027 While rst=1, rdata1 and rdata2 SHALL be 0.

Verification
REQ-028 Write and read: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, 1 edge -> wb outputs 5/1/0xDEADBEEF; raddr1=5, re1=1 -> rdata1=0xDEADBEEF by bypass before the 2nd edge and from the array after it.
REQ-029 Zero register: write 0x12345678 to address 0 -> rdata1 and rdata2 at raddr=0 read 0 both before and after the write.
REQ-030 Stall and flush: capture r3=0xAAAA0000, then stall=1 for 3 cycles with new mem inputs -> wb outputs held at 3/1/0xAAAA0000; flush=1 and stall=1 together -> wb_wreg=0 and r3 keeps 0xAAAA0000.
REQ-031 Read enable: re2=0 with raddr2=3 holding 0xAAAA0000 -> rdata2=0; re2=1 -> rdata2=0xAAAA0000.
REQ-032 Reset mid-op: wb holds 7/1/0x55 and rst is asserted on the next edge -> r7 stays 0; all wb outputs read 0.
REQ-033 Back-to-back writes: r9=1 then r9=2 in consecutive cycles -> rdata1 at raddr1=9 reads 1, then 2 (bypass), then 2 from the array.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register plus a 32x32 register file with two combinational read ports.
// The WB stage contents are exported for forwarding, and the read ports bypass a pending write.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        re1,
  input  logic        re2,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata
);

  logic [31:0] regs [32];

  // Flush wins over stall so that a bubble can be forced into a held stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd    <= 5'd0;
      wb_wreg  <= 1'b0;
      wb_wdata <= 32'h0000_0000;
    end else if (flush) begin
      wb_wd    <= 5'd0;
      wb_wreg  <= 1'b0;
      wb_wdata <= 32'h0000_0000;
    end else if (!stall) begin
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg;
      wb_wdata <= mem_wdata;
    end
  end

  // The array write ignores stall: a held stage simply rewrites the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (wb_wreg && (wb_wd != 5'd0)) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  assign rdata1 = (rst || (raddr1 == 5'd0) || !re1) ? 32'h0000_0000 :
                  (wb_wreg && (raddr1 == wb_wd))    ? wb_wdata      :
                                                      regs[raddr1];

  assign rdata2 = (rst || (raddr2 == 5'd0) || !re2) ? 32'h0000_0000 :
                  (wb_wreg && (raddr2 == wb_wd))    ? wb_wdata      :
                                                      regs[raddr2];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        flush;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  logic [31:0] model_rf [32];
  logic [4:0]  model_wd    = 5'd0;
  logic        model_wreg  = 1'b0;
  logic [31:0] model_wdata = 32'h0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stall(stall), .flush(flush),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
  end

  // Reference model: a pending WB write lands in the array, then the stage register advances.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      model_wd = 5'd0; model_wreg = 1'b0; model_wdata = 32'h0;
    end else begin
      if (model_wreg && model_wd != 5'd0) model_rf[model_wd] = model_wdata;
      if (flush) begin
        model_wd = 5'd0; model_wreg = 1'b0; model_wdata = 32'h0;
      end else if (!stall) begin
        model_wd = mem_wd; model_wreg = mem_wreg; model_wdata = mem_wdata;
      end
    end
  end

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] addr);
    if (rst || addr == 5'd0 || !re) return 32'h0;
    if (model_wreg && addr == model_wd) return model_wdata;
    return model_rf[addr];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("cyc_wb_wd",    {27'h0, wb_wd},   {27'h0, model_wd});
      check_output("cyc_wb_wreg",  {31'h0, wb_wreg}, {31'h0, model_wreg});
      check_output("cyc_wb_wdata", wb_wdata,         model_wdata);
      check_output("cyc_rdata1",   rdata1,           model_read(re1, raddr1));
      check_output("cyc_rdata2",   rdata2,           model_read(re2, raddr2));
    end
  end

  task automatic apply_stimulus(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic st, input logic fl);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata; stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reads(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
  endtask

  task automatic check_wb(input string name, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    check_output({name, "_wd"},    {27'h0, wb_wd},   {27'h0, wd});
    check_output({name, "_wreg"},  {31'h0, wb_wreg}, {31'h0, wreg});
    check_output({name, "_wdata"}, wb_wdata,         wdata);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    set_reads(1'b1, 5'd5, 1'b1, 5'd5);
    check_output("reset_rdata1_comb", rdata1, 32'h0);
    step();
    check_wb("reset", 5'd0, 1'b0, 32'h0);
    check_output("reset_rdata2", rdata2, 32'h0);
    rst = 1'b0;
    check_en = 1'b1;

    // Write and read through the bypass, then from the array.
    apply_stimulus(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    check_wb("wr5", 5'd5, 1'b1, 32'hDEADBEEF);
    apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    set_reads(1'b1, 5'd5, 1'b0, 5'd0);
    check_output("r5_bypass", rdata1, 32'hDEADBEEF);
    step();
    check_output("r5_array", rdata1, 32'hDEADBEEF);

    // Register zero is never written and never bypassed.
    apply_stimulus(5'd0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    set_reads(1'b1, 5'd0, 1'b1, 5'd0);
    check_output("r0_before_1", rdata1, 32'h0);
    step();
    apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("r0_pending_1", rdata1, 32'h0);
    check_output("r0_pending_2", rdata2, 32'h0);
    step();
    check_output("r0_after_2", rdata2, 32'h0);

    // Stall holds the stage; flush wins over stall.
    apply_stimulus(5'd3, 1'b1, 32'hAAAA0000, 1'b0, 1'b0);
    step();
    apply_stimulus(5'd4, 1'b1, 32'h11111111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_wb("stall", 5'd3, 1'b1, 32'hAAAA0000);
    end
    apply_stimulus(5'd4, 1'b1, 32'h11111111, 1'b1, 1'b1);
    step();
    check_wb("flush", 5'd0, 1'b0, 32'h0);
    apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    set_reads(1'b1, 5'd3, 1'b1, 5'd4);
    check_output("r3_kept", rdata1, 32'hAAAA0000);
    check_output("r4_unwritten", rdata2, 32'h0);

    // Read enable gating.
    set_reads(1'b1, 5'd3, 1'b0, 5'd3);
    check_output("re2_off", rdata2, 32'h0);
    set_reads(1'b1, 5'd3, 1'b1, 5'd3);
    check_output("re2_on", rdata2, 32'hAAAA0000);
    check_output("same_addr", rdata1, rdata2);

    // A non-writing entry leaves the array alone.
    apply_stimulus(5'd10, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    step();
    step();
    set_reads(1'b1, 5'd10, 1'b1, 5'd3);
    check_output("r10_nowrite", rdata1, 32'h0);

    // Reset mid-operation discards the pending write.
    apply_stimulus(5'd7, 1'b1, 32'h00000055, 1'b0, 1'b0);
    step();
    check_wb("pend7", 5'd7, 1'b1, 32'h55);
    rst = 1'b1;
    apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    set_reads(1'b1, 5'd7, 1'b1, 5'd3);
    check_output("rst_rdata1", rdata1, 32'h0);
    check_output("rst_rdata2", rdata2, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check_wb("midrst", 5'd0, 1'b0, 32'h0);
    check_output("r7_dropped", rdata1, 32'h0);
    check_output("r3_cleared", rdata2, 32'h0);

    // Back-to-back writes to the same register.
    apply_stimulus(5'd9, 1'b1, 32'h1, 1'b0, 1'b0);
    step();
    apply_stimulus(5'd9, 1'b1, 32'h2, 1'b0, 1'b0);
    set_reads(1'b1, 5'd9, 1'b0, 5'd0);
    check_output("r9_first", rdata1, 32'h1);
    step();
    apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("r9_bypass", rdata1, 32'h2);
    step();
    check_output("r9_array", rdata1, 32'h2);

    // Mixed traffic checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom(),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      re1 = 1'($urandom_range(0, 3) != 0);
      re2 = 1'($urandom_range(0, 3) != 0);
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = (i % 4 == 0) ? raddr1 : 5'($urandom_range(0, 31));
      step();
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
